// File: rtl/demux2_stream_pkg.sv
// demux2_stream_pkg: shared types for the two-way stream demultiplexer.
package demux2_stream_pkg;
   typedef enum logic [1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_FULL  = 2'd2
   } cnt_e;
endpackage

// File: rtl/demux2_stream_if.sv
// demux2_stream_if: single input stream plus two output channels, grouped for the demux ports.
interface demux2_stream_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] d;
   logic             a;
   logic             d_valid;
   logic             d_ready;
   logic [WIDTH-1:0] q0;
   logic             q0_valid;
   logic             q0_ready;
   logic [WIDTH-1:0] q1;
   logic             q1_valid;
   logic             q1_ready;
   modport master (
      output d, a, d_valid, q0_ready, q1_ready,
      input  d_ready, q0, q0_valid, q1, q1_valid
   );
   modport slave (
      input  d, a, d_valid, q0_ready, q1_ready,
      output d_ready, q0, q0_valid, q1, q1_valid
   );
endinterface

// File: rtl/demux2_stream_fifo.sv
// demux_fifo2: 2-entry FIFO, head always in r_m0 so the output needs no read mux.
module demux_fifo2
   import demux2_stream_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_head,
   output logic             o_valid,
   output logic             o_full
);
   cnt_e             r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] r_m0, r_m1, w_m0_nxt, w_m1_nxt;
   logic             w_push, w_pop;

   assign o_full  = (r_cnt == CNT_FULL);
   assign o_valid = (r_cnt != CNT_EMPTY);
   assign o_head  = r_m0;
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & o_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= CNT_EMPTY;
         r_m0  <= '0;
         r_m1  <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_m0  <= w_m0_nxt;
         r_m1  <= w_m1_nxt;
      end
   end

   // Push+pop at one entry replaces the head in place and keeps the count.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_m0_nxt  = r_m0;
      w_m1_nxt  = r_m1;
      case (r_cnt)
         CNT_EMPTY: begin
            w_m0_nxt  = w_push ? i_data : r_m0;
            w_cnt_nxt = w_push ? CNT_ONE : CNT_EMPTY;
         end
         CNT_ONE: begin
            w_m0_nxt  = (w_push & w_pop) ? i_data : r_m0;
            w_m1_nxt  = (w_push & ~w_pop) ? i_data : r_m1;
            w_cnt_nxt = (w_push & ~w_pop) ? CNT_FULL : (w_pop & ~w_push) ? CNT_EMPTY : CNT_ONE;
         end
         CNT_FULL: begin
            w_m0_nxt  = w_pop ? r_m1 : r_m0;
            w_cnt_nxt = w_pop ? CNT_ONE : CNT_FULL;
         end
         default: w_cnt_nxt = CNT_EMPTY;
      endcase
   end
endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: steers each accepted word to one of two buffered channels by select a.
module demux2_stream #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   demux2_stream_if.slave     io_bus
);
   logic w_full0, w_full1, w_fire, w_push0, w_push1, w_pop0, w_pop1;
   logic w_valid0, w_valid1;
   logic [WIDTH-1:0] w_head0, w_head1;

   // Ready looks only at registered occupancy, so no sink ready reaches d_ready.
   assign io_bus.d_ready  = io_bus.a ? ~w_full1 : ~w_full0;
   assign w_fire          = io_bus.d_valid & io_bus.d_ready;
   assign w_push0         = w_fire & ~io_bus.a;
   assign w_push1         = w_fire & io_bus.a;
   assign w_pop0          = w_valid0 & io_bus.q0_ready;
   assign w_pop1          = w_valid1 & io_bus.q1_ready;
   assign io_bus.q0       = w_head0;
   assign io_bus.q1       = w_head1;
   assign io_bus.q0_valid = w_valid0;
   assign io_bus.q1_valid = w_valid1;

   demux_fifo2 #(.WIDTH(WIDTH)) u_ch0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push0),
      .i_pop   (w_pop0),
      .i_data  (io_bus.d),
      .o_head  (w_head0),
      .o_valid (w_valid0),
      .o_full  (w_full0)
   );

   demux_fifo2 #(.WIDTH(WIDTH)) u_ch1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push1),
      .i_pop   (w_pop1),
      .i_data  (io_bus.d),
      .o_head  (w_head1),
      .o_valid (w_valid1),
      .o_full  (w_full1)
   );
endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: directed and random checks of demux2_stream with per-channel scoreboards.
module tb_demux2_stream;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   logic [7:0] sb0[$];
   logic [7:0] sb1[$];

   always #5 clk = ~clk;

   demux2_stream_if #(.WIDTH(8)) bus ();

   demux2_stream #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic sel, input logic [7:0] data);
      bus.d_valid = v;
      bus.a       = sel;
      bus.d       = data;
      #1;
   endtask

   initial begin
      bus.d = '0; bus.a = 1'b0; bus.d_valid = 1'b0; bus.q0_ready = 1'b0; bus.q1_ready = 1'b0;
      // reset and idle
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_q0_valid", bus.q0_valid, 0);
      chk("rst_q1_valid", bus.q1_valid, 0);
      chk("rst_q0", bus.q0, 0);
      chk("rst_q1", bus.q1, 0);
      drive(0, 0, 8'h00); chk("rst_ready_a0", bus.d_ready, 1);
      drive(0, 1, 8'h00); chk("rst_ready_a1", bus.d_ready, 1);
      // alternating steer, both sinks ready
      bus.q0_ready = 1'b1; bus.q1_ready = 1'b1;
      drive(1, 0, 8'h11); chk("alt_ready1", bus.d_ready, 1);
      tick();
      drive(1, 1, 8'h22); chk("alt_q0_11", bus.q0, 8'h11); chk("alt_q0v1", bus.q0_valid, 1); chk("alt_ready2", bus.d_ready, 1);
      tick();
      drive(1, 0, 8'h33); chk("alt_q1_22", bus.q1, 8'h22); chk("alt_q1v", bus.q1_valid, 1); chk("alt_q0v_gap", bus.q0_valid, 0); chk("alt_ready3", bus.d_ready, 1);
      tick();
      drive(0, 0, 8'h00); chk("alt_q0_33", bus.q0, 8'h33); chk("alt_q0v2", bus.q0_valid, 1); chk("alt_q1v_gap", bus.q1_valid, 0);
      tick();
      chk("alt_empty", bus.q0_valid, 0);
      // channel 0 stall
      bus.q0_ready = 1'b0;
      drive(1, 0, 8'hA0); chk("st_ready_a0", bus.d_ready, 1);
      tick();
      drive(1, 0, 8'hA1); chk("st_ready_a1", bus.d_ready, 1); chk("st_head_a0", bus.q0, 8'hA0);
      tick();
      drive(1, 0, 8'hA2); chk("st_full_ready", bus.d_ready, 0);
      tick();
      chk("st_still_full", bus.d_ready, 0); chk("st_head_hold", bus.q0, 8'hA0);
      bus.q0_ready = 1'b1; #1;
      chk("st_ready_regd", bus.d_ready, 0);
      tick();
      chk("st_pop_a1", bus.q0, 8'hA1); chk("st_space", bus.d_ready, 1);
      tick();
      drive(0, 0, 8'h00); chk("st_pop_a2", bus.q0, 8'hA2); chk("st_a2_valid", bus.q0_valid, 1);
      tick();
      chk("st_drained", bus.q0_valid, 0);
      // isolation: channel 0 full and stalled
      bus.q0_ready = 1'b0; bus.q1_ready = 1'b0;
      drive(1, 0, 8'hB0); tick();
      drive(1, 0, 8'hB1); tick();
      drive(1, 1, 8'hB5); chk("iso_ready_a1", bus.d_ready, 1);
      tick();
      drive(0, 1, 8'h00); chk("iso_q1", bus.q1, 8'hB5); chk("iso_q1v", bus.q1_valid, 1); chk("iso_q0", bus.q0, 8'hB0);
      drive(0, 0, 8'h00); chk("iso_ready_a0", bus.d_ready, 0);
      bus.q0_ready = 1'b1; tick();
      chk("iso_q0_b1", bus.q0, 8'hB1);
      tick();
      chk("iso_q0_empty", bus.q0_valid, 0); chk("iso_q1_kept", bus.q1, 8'hB5);
      // push+pop at count 1
      bus.q1_ready = 1'b1; tick();
      chk("pp_q1_empty", bus.q1_valid, 0);
      bus.q1_ready = 1'b0;
      drive(1, 1, 8'hC0); tick();
      bus.q1_ready = 1'b1;
      drive(1, 1, 8'hC1); chk("pp_ready", bus.d_ready, 1); chk("pp_head_c0", bus.q1, 8'hC0);
      tick();
      bus.q1_ready = 1'b0;
      drive(0, 1, 8'h00); chk("pp_head_c1", bus.q1, 8'hC1); chk("pp_valid", bus.q1_valid, 1); chk("pp_count1", bus.d_ready, 1);
      drive(1, 1, 8'hC2); tick();
      drive(0, 1, 8'h00); chk("pp_now_full", bus.d_ready, 0); chk("pp_head_kept", bus.q1, 8'hC1);
      // async reset mid-stream
      #2 rst_n = 1'b0; #1;
      chk("arst_q1v", bus.q1_valid, 0); chk("arst_q1", bus.q1, 0); chk("arst_ready", bus.d_ready, 1);
      tick();
      rst_n = 1'b1;
      tick();
      // random traffic against scoreboards
      for (int i = 0; i < 10000; i++) begin
         bus.q0_ready = 1'($urandom_range(0, 1));
         bus.q1_ready = 1'($urandom_range(0, 1));
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
         chk("rnd_ready", bus.d_ready, bus.a ? (sb1.size() != 2) : (sb0.size() != 2));
         chk("rnd_q0v", bus.q0_valid, sb0.size() != 0);
         chk("rnd_q1v", bus.q1_valid, sb1.size() != 0);
         if (sb0.size() != 0) chk("rnd_q0", bus.q0, sb0[0]);
         if (sb1.size() != 0) chk("rnd_q1", bus.q1, sb1[0]);
         bus.q0_ready = ~bus.q0_ready; bus.q1_ready = ~bus.q1_ready; #1;
         chk("rnd_ready_indep", bus.d_ready, bus.a ? (sb1.size() != 2) : (sb0.size() != 2));
         bus.q0_ready = ~bus.q0_ready; bus.q1_ready = ~bus.q1_ready; #1;
         if (bus.q0_ready && sb0.size() != 0) void'(sb0.pop_front());
         if (bus.q1_ready && sb1.size() != 0) void'(sb1.pop_front());
         if (bus.d_valid && !bus.a && sb0.size() < 2 + (bus.q0_ready ? 0 : 0) && bus.d_ready) sb0.push_back(bus.d);
         if (bus.d_valid && bus.a && bus.d_ready) sb1.push_back(bus.d);
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
